// File: rtl/progmem_boot_pkg.sv
// ============================================================
// progmem_boot_pkg: shared loader states and frame constants
// Rev 1.0
// ============================================================
`default_nettype none

package progmem_boot_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6,
    ERROR = 3'd7
  } boot_state_e;

  localparam logic [7:0] MAGIC_BYTE = 8'hA5;
  localparam int         WORD_BYTES = 4;
endpackage

`default_nettype wire

// File: rtl/boot_word_packer.sv
// ============================================================
// boot_word_packer: byte lanes -> little-endian word, running XOR
// Rev 1.0
// ============================================================
`default_nettype none

module boot_word_packer
  import progmem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_en,
  output logic [31:0] word_out,
  output logic        word_full,
  output logic [7:0]  chk
);

  logic [1:0] cnt;

  // Asserted alongside the byte that completes a word, so the word is whole on the next cycle.
  assign word_full = byte_en && (cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt      <= 2'd0;
      chk      <= 8'd0;
      word_out <= 32'd0;
    end else if (byte_en) begin
      word_out[{cnt, 3'b000} +: 8] <= byte_in;
      chk                          <= chk ^ byte_in;
      cnt                          <= cnt + 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/progmem_boot_loader.sv
// ============================================================
// progmem_boot_loader: UART boot image loader, holds core until done
// Rev 1.0
// ============================================================
`default_nettype none

module progmem_boot_loader
  import progmem_boot_pkg::*;
#(
  parameter int         ADDR_W       = 14,
  parameter int         MAX_WORDS    = 4096,
  parameter logic [7:0] MAGIC        = MAGIC_BYTE,
  parameter int         IDLE_TIMEOUT = 1_000_000,
  parameter int         BYTE_TIMEOUT = 100_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_din,
  output logic              cpu_hold,
  output logic              boot_done,
  output logic              boot_error,
  output logic [15:0]       words_loaded
);

  boot_state_e       state;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [ADDR_W-3:0] word_idx;
  logic [31:0]       idle_cnt;
  logic [31:0]       byte_tmr;
  logic              accept;
  logic              byte_en;
  logic              clr;
  logic              word_full;
  logic              timeout;
  logic [31:0]       word;
  logic [7:0]        chk;
  logic [15:0]       len_rx;

  assign rx_ready = !rst && (state != WRITE) && (state != DONE);
  assign accept   = rx_valid && rx_ready;
  assign byte_en  = accept && (state == DATA);
  assign clr      = accept && (state == LEN1);
  assign len_rx   = {rx_data, len_lo};
  assign timeout  = byte_tmr >= 32'(BYTE_TIMEOUT - 1);

  assign mem_we   = (state == WRITE);
  assign mem_addr = (state == WRITE) ? {word_idx, 2'b00} : cpu_addr;
  assign mem_din  = word;

  boot_word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .byte_in  (rx_data),
    .byte_en  (byte_en),
    .word_out (word),
    .word_full(word_full),
    .chk      (chk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cpu_hold     <= 1'b1;
      boot_done    <= 1'b0;
      boot_error   <= 1'b0;
      words_loaded <= 16'd0;
      word_idx     <= '0;
      len          <= 16'd0;
      len_lo       <= 8'd0;
      idle_cnt     <= 32'd0;
      byte_tmr     <= 32'd0;
    end else begin
      // Free-running gap timer; only inspected while a frame is in flight.
      byte_tmr <= accept ? 32'd0 : byte_tmr + 32'd1;
      case (state)
        IDLE: begin
          if (accept && rx_data == MAGIC) begin
            state        <= LEN0;
            words_loaded <= 16'd0;
          end else if (idle_cnt == 32'(IDLE_TIMEOUT - 1)) begin
            state     <= DONE;
            cpu_hold  <= 1'b0;
            boot_done <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end
        LEN0: begin
          if (accept) begin
            len_lo <= rx_data;
            state  <= LEN1;
          end else if (timeout) begin
            state      <= ERROR;
            boot_error <= 1'b1;
          end
        end
        LEN1: begin
          if (accept) begin
            len <= len_rx;
            if (32'(len_rx) > 32'(MAX_WORDS)) begin
              state      <= ERROR;
              boot_error <= 1'b1;
            end else if (len_rx == 16'd0) begin
              state <= CHECK;
            end else begin
              state    <= DATA;
              word_idx <= '0;
            end
          end else if (timeout) begin
            state      <= ERROR;
            boot_error <= 1'b1;
          end
        end
        DATA: begin
          if (word_full) begin
            state <= WRITE;
          end else if (!accept && timeout) begin
            state      <= ERROR;
            boot_error <= 1'b1;
          end
        end
        WRITE: begin
          word_idx     <= word_idx + 1'b1;
          words_loaded <= words_loaded + 16'd1;
          // words_loaded is 16 bits wide, so the last-word test cannot overflow like word_idx.
          state        <= (words_loaded + 16'd1 == len) ? CHECK : DATA;
        end
        CHECK: begin
          if (accept) begin
            if (rx_data == chk) begin
              state     <= DONE;
              cpu_hold  <= 1'b0;
              boot_done <= 1'b1;
            end else begin
              state      <= ERROR;
              boot_error <= 1'b1;
            end
          end else if (timeout) begin
            state      <= ERROR;
            boot_error <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        ERROR: begin
          if (accept && rx_data == MAGIC) begin
            state        <= LEN0;
            boot_error   <= 1'b0;
            words_loaded <= 16'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
